// File: rtl/smac_pkg.sv
// Shared types for the smac accumulation controller: FSM encoding, lane layout
// of the 64-bit packed vector, and the precision-to-lane mask expansion.
package smac_pkg;

    localparam int VEC_W  = 64;
    localparam int PREC_W = 4;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_RUN    = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    localparam int LANE0_LSB = 0;
    localparam int LANE0_MSB = 7;
    localparam int LANE1_LSB = 8;
    localparam int LANE1_MSB = 15;
    localparam int LANE2_LSB = 16;
    localparam int LANE2_MSB = 31;
    localparam int LANE3_LSB = 32;
    localparam int LANE3_MSB = 63;

    function automatic logic [VEC_W-1:0] lane_mask(input logic [PREC_W-1:0] prec);
        logic [VEC_W-1:0] m;
        m = '0;
        m[LANE0_MSB:LANE0_LSB] = {(LANE0_MSB - LANE0_LSB + 1){prec[0]}};
        m[LANE1_MSB:LANE1_LSB] = {(LANE1_MSB - LANE1_LSB + 1){prec[1]}};
        m[LANE2_MSB:LANE2_LSB] = {(LANE2_MSB - LANE2_LSB + 1){prec[2]}};
        m[LANE3_MSB:LANE3_LSB] = {(LANE3_MSB - LANE3_LSB + 1){prec[3]}};
        return m;
    endfunction

endpackage

// File: rtl/smac_lane_mask.sv
// Combinational expander from a 4-bit lane enable to a 64-bit bit mask.
// Zero latency; no flow control.
module smac_lane_mask
    import smac_pkg::*;
(
    input  logic [PREC_W-1:0] i_prec,
    output logic [VEC_W-1:0]  o_mask
);

    assign o_mask = lane_mask(i_prec);

endmodule

// File: rtl/smac_acc_ctrl.sv
// Sequences operand beats into the smac array and accumulates one masked 64-bit result per vector.
// Latency: DSP_LATENCY+2 cycles from accepting a beat to its capture/OUT; beats issue one at a time.
// Backpressure: in_ready only in ACCEPT; OUT holds the result until out_ready. SMAC_ACC_PERF_EN adds perf counters.
module smac_acc_ctrl
    import smac_pkg::*;
#(
    parameter int bit_width    = 8,
    parameter int DSP_LATENCY  = 3,
    parameter bit ACTIVE_CHAIN = 1'b0
) (
    input  logic                           clk,
    input  logic                           sclr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [bit_width*bit_width-1:0] in_data,
    input  logic [bit_width*bit_width-1:0] in_weight,
    input  logic [PREC_W-1:0]              in_precision,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [bit_width*bit_width-1:0] out_result,
    output logic                           mac_ce,
    output logic                           mac_sclr,
    output logic [bit_width*bit_width-1:0] mac_data_input,
    output logic [bit_width*bit_width-1:0] mac_weight,
    output logic [bit_width*bit_width-1:0] mac_res_p,
    input  logic [bit_width*bit_width-1:0] mac_res_n,
    output logic [PREC_W-1:0]              mac_select_precision,
    output logic [1:0]                     mac_enable_fp_unit,
    output logic                           mac_active_chain,
    output logic                           busy
`ifdef SMAC_ACC_PERF_EN
    ,
    output logic [31:0]                    perf_beats,
    output logic [31:0]                    perf_stall
`endif
);

    localparam logic [3:0] LAT_INIT = 4'(DSP_LATENCY);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_data;
    logic [VEC_W-1:0]   r_weight;
    logic               r_last;
    logic [PREC_W-1:0]  r_prec;
    logic [VEC_W-1:0]   r_acc;
    logic [3:0]         r_cnt;
    logic               r_first;
    logic               r_start_clr;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_mac_ce;
    logic               w_accept;
    logic               w_out_hs;
    logic [VEC_W-1:0]   w_mask;

    smac_lane_mask u_lane_mask (
        .i_prec (r_prec),
        .o_mask (w_mask)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_mac_ce    = 1'b0;
        unique case (r_state)
            ST_ACCEPT: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_mac_ce = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = r_last ? ST_OUT : ST_ACCEPT;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    assign in_ready = w_in_ready & ~sclr;
    assign w_accept = in_valid & in_ready;
    assign w_out_hs = w_out_valid & out_ready;

    // res_mac_n is valid only after DSP_LATENCY CE edges with the operands
    // already on the smac inputs, so the capture lands on one further edge.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state     <= ST_ACCEPT;
            r_data      <= '0;
            r_weight    <= '0;
            r_last      <= 1'b0;
            r_prec      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b1;
            r_start_clr <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_clr <= w_out_hs;
            if (w_accept) begin
                r_data   <= in_data;
                r_weight <= in_weight;
                r_last   <= in_last;
                r_cnt    <= LAT_INIT;
                r_first  <= 1'b0;
                if (r_first) begin
                    r_prec <= in_precision;
                    r_acc  <= '0;
                end
            end
            if (r_state == ST_RUN) begin
                if (r_cnt == 4'd0) begin
                    r_acc <= mac_res_n & w_mask;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if (w_out_hs) begin
                r_first <= 1'b1;
            end
        end
    end

    assign out_valid            = w_out_valid;
    assign out_result           = w_out_valid ? r_acc : '0;
    assign mac_ce               = w_mac_ce;
    assign mac_sclr             = sclr | r_start_clr;
    assign mac_data_input       = r_data;
    assign mac_weight           = r_weight;
    assign mac_res_p            = r_acc;
    assign mac_select_precision = r_prec;
    assign mac_enable_fp_unit   = 2'b00;
    assign mac_active_chain     = ACTIVE_CHAIN;
    assign busy                 = (r_state != ST_ACCEPT);

`ifdef SMAC_ACC_PERF_EN
    logic [31:0] r_perf_beats;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_perf_beats <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept && (r_perf_beats != '1)) begin
                r_perf_beats <= r_perf_beats + 32'd1;
            end
            if (w_out_valid && !out_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_beats = r_perf_beats;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_smac_acc_ctrl.sv
// Bench for smac_acc_ctrl: a latency-accurate smac model closes the loop, and a
// per-vector lane-arithmetic model checks every issued beat and emitted result.
module tb_smac_acc_ctrl;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [63:0] in_weight = '0;
    logic [3:0]  in_precision = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic        mac_ce;
    logic        mac_sclr;
    logic [63:0] mac_data_input;
    logic [63:0] mac_weight;
    logic [63:0] mac_res_p;
    logic [63:0] mac_res_n;
    logic [3:0]  mac_select_precision;
    logic [1:0]  mac_enable_fp_unit;
    logic        mac_active_chain;
    logic        busy;
`ifdef SMAC_ACC_PERF_EN
    logic [31:0] perf_beats;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    smac_acc_ctrl #(.bit_width(8), .DSP_LATENCY(L), .ACTIVE_CHAIN(1'b0)) dut (
        .clk(clk), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .in_precision(in_precision), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .mac_ce(mac_ce), .mac_sclr(mac_sclr), .mac_data_input(mac_data_input),
        .mac_weight(mac_weight), .mac_res_p(mac_res_p), .mac_res_n(mac_res_n),
        .mac_select_precision(mac_select_precision), .mac_enable_fp_unit(mac_enable_fp_unit),
        .mac_active_chain(mac_active_chain), .busy(busy)
`ifdef SMAC_ACC_PERF_EN
        , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent lanes, each wrapping at its own width.
    function automatic logic [63:0] lanes_mac(input logic [63:0] acc, input logic [63:0] d,
                                              input logic [63:0] w);
        logic [63:0] r;
        r[7:0]   = acc[7:0]   + d[7:0]   * w[7:0];
        r[15:8]  = acc[15:8]  + d[15:8]  * w[15:8];
        r[31:16] = acc[31:16] + d[31:16] * w[31:16];
        r[63:32] = acc[63:32] + d[63:32] * w[63:32];
        return r;
    endfunction

    function automatic logic [63:0] mask_of(input logic [3:0] p);
        return {{32{p[3]}}, {16{p[2]}}, {8{p[1]}}, {8{p[0]}}};
    endfunction

    // smac: L-deep CE-gated pipeline, cleared by its sclr.
    logic [63:0] pipe [L];
    always @(posedge clk) begin
        if (mac_sclr) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else if (mac_ce) begin
            pipe[0] <= lanes_mac(mac_res_p, mac_data_input, mac_weight);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mac_res_n = pipe[L-1];

    logic rdy_rand = 1'b0;
    logic rdy_force = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    logic [63:0] exp_q[$];
    int          lat_q[$];
    logic [63:0] got_q[$];
    logic        m_first = 1'b1;
    logic [63:0] m_acc = '0;
    logic [3:0]  m_prec = '0;
    logic [63:0] cur_resp = '0, cur_d = '0, cur_w = '0;
    logic [3:0]  cur_prec = '0;
    logic        prev_ov = 1'b0, prev_stall = 1'b0, prev_sclr = 1'b0;
    logic [63:0] held = '0;
    int          cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (sclr) begin
            chk("sclr_in_ready", in_ready, 0);
            chk("sclr_mac_sclr", mac_sclr, 1);
            m_first = 1'b1;
            m_acc = '0;
            exp_q.delete();
            lat_q.delete();
            prev_ov = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_sclr) begin
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_result", out_result, 0);
                chk("rst_mac_ce", mac_ce, 0);
                chk("rst_mac_sclr", mac_sclr, 0);
                chk("rst_mac_data", mac_data_input, 0);
                chk("rst_mac_weight", mac_weight, 0);
                chk("rst_mac_res_p", mac_res_p, 0);
                chk("rst_mac_prec", mac_select_precision, 0);
                chk("rst_fp_unit", mac_enable_fp_unit, 0);
                chk("rst_active_chain", mac_active_chain, 0);
                chk("rst_busy", busy, 0);
            end
            chk("in_ready_vs_busy", in_ready, !busy);
            if (mac_ce || out_valid) chk("busy", busy, 1);
            if (mac_ce) begin
                chk("res_p", mac_res_p, cur_resp);
                chk("issue_data", mac_data_input, cur_d);
                chk("issue_weight", mac_weight, cur_w);
                chk("select_prec", mac_select_precision, cur_prec);
                chk("ce_no_valid", out_valid, 0);
            end
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
                else chk("latency", cyc - lat_q.pop_front(), L + 2);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", out_result, held);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_result);
                if (exp_q.size() == 0) chk("result_unexpected", out_valid, 0);
                else chk("result", out_result, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                if (m_first) begin
                    m_prec = in_precision;
                    m_acc = '0;
                end
                cur_resp = m_acc;
                cur_d = in_data;
                cur_w = in_weight;
                cur_prec = m_prec;
                m_acc = lanes_mac(m_acc, in_data, in_weight) & mask_of(m_prec);
                m_first = in_last;
                if (in_last) begin
                    exp_q.push_back(m_acc);
                    lat_q.push_back(cyc);
                end
            end
            prev_ov = out_valid;
            prev_stall = out_valid & !out_ready;
            held = out_result;
        end
        prev_sclr = sclr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [63:0] w,
                             input logic [3:0] p, input logic last);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_weight = w;
        in_precision = p;
        in_last = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic expect_result(input logic [63:0] lit, input string name);
        for (int k = 0; k < 300 && got_q.size() == 0; k++) tick();
        chk({name, "_present"}, got_q.size() > 0, 1);
        if (got_q.size() > 0) chk(name, got_q.pop_front(), lit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic [3:0] p;
        repeat (3) tick();
        sclr = 1'b0;
        tick();

        send_beat(64'h3, 64'h4, 4'b0001, 1'b1);
        expect_result(64'h0000_0000_0000_000C, "t1_single");

        send_beat(64'h0000_03E8_0000_00C8, 64'h0000_07D0_0000_0002, 4'b1111, 1'b0);
        send_beat(64'h0000_0005_0000_0064, 64'h0000_0007_0000_0003, 4'b1111, 1'b1);
        expect_result(64'h001E_84A3_0000_00BC, "t2_two_beat");

        send_beat(64'h0000_0007_0000_1005, 64'h0000_0003_0000_1005, 4'b0010, 1'b1);
        expect_result(64'h0, "t3_wrap");

        rdy_force = 1'b0;
        send_beat(64'h0000_0002_0003_0405, 64'h0000_0003_0004_0506, 4'b1111, 1'b1);
        for (int k = 0; k < 100 && !out_valid; k++) tick();
        chk("bp_out_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data = 64'h1;
        in_weight = 64'h1;
        in_precision = 4'b0001;
        in_last = 1'b1;
        repeat (10) tick();
        rdy_force = 1'b1;
        @(negedge clk);
        chk("bp_release_hs", out_valid & out_ready, 1);
        chk("bp_in_ready_hs", in_ready, 0);
        @(negedge clk);
        chk("bp_next_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_result(64'h0000_0006_000C_141E, "t4_stalled");
        expect_result(64'h1, "t4_next_cleared");

        send_beat(64'h1, 64'h9, 4'b0001, 1'b0);
        send_beat(64'h1, 64'h9, 4'b0001, 1'b1);
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        repeat (L + 6) tick();
        chk("t5_no_result", got_q.size(), 0);
        send_beat(64'h2, 64'h3, 4'b0001, 1'b1);
        expect_result(64'h6, "t5_after_sclr");

        send_beat(64'h0000_0009_0000_0003, 64'h0000_0009_0000_0004, 4'b0001, 1'b0);
        send_beat(64'h0000_0007_0000_0002, 64'h0000_0007_0000_0005, 4'b1000, 1'b1);
        expect_result(64'h16, "t6_prec_hold");

        got_q.delete();
        rdy_rand = 1'b1;
        for (int v = 0; v < 40; v++) begin
            nb = $urandom_range(1, 4);
            p = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            for (int b = 0; b < nb; b++) begin
                send_beat({$urandom, $urandom}, {$urandom, $urandom},
                          (b == 0) ? p : 4'($urandom), b == nb - 1);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        for (int k = 0; k < 500 && (exp_q.size() != 0 || busy); k++) tick();
        chk("drain_empty", exp_q.size(), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
